// File: rtl/mem_pkg.sv
// Shared types and limits for the memory access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

  localparam int unsigned MAX_WAIT_STATES = 15;
  localparam int unsigned WAIT_CNT_W      = 4;
  localparam int unsigned MEM_IN_W        = 32;

endpackage

// File: rtl/memory_access_unit_if.sv
// Request/response bundle between the control unit/MDR side and the memory access unit.
// AddrFault exists only when MEM_ADDR_CHECK_EN is defined.
interface memory_access_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  Read;
  logic                  Write;
  logic [31:0]           MemoryIn;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  MemDone;
  logic                  Busy;
`ifdef MEM_ADDR_CHECK_EN
  logic                  AddrFault;

  modport master (output Read, Write, MemoryIn, WriteData,
                  input  ReadData, MemDone, Busy, AddrFault);
  modport slave  (input  Read, Write, MemoryIn, WriteData,
                  output ReadData, MemDone, Busy, AddrFault);
`else
  modport master (output Read, Write, MemoryIn, WriteData,
                  input  ReadData, MemDone, Busy);
  modport slave  (input  Read, Write, MemoryIn, WriteData,
                  output ReadData, MemDone, Busy);
`endif
endinterface

// File: rtl/ram_sp.sv
// Single-port word RAM: synchronous write, registered read of the presented address.
module ram_sp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter              INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_access_unit.sv
// One read or write per request against an internal word RAM with programmable wait states.
// Optional feature: MEM_ADDR_CHECK_EN adds AddrFault and blocks out-of-range accesses.
module memory_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned WAIT_STATES = 1,
  parameter              INIT_FILE   = ""
) (
  input logic                 clock,
  input logic                 clear,
  memory_access_unit_if.slave bus
);

  localparam int unsigned WAIT_LOAD =
    (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;

  mem_state_e                state_q, state_d;
  mem_op_e                   op_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [WAIT_CNT_W-1:0]     cnt_q;
  logic [DATA_WIDTH-1:0]     read_data_q;
  logic                      done_q;
  logic                      busy_q;
  logic                      accept_c;
  logic                      commit_c;
  logic                      we_c;
  logic                      oob_c;
  logic                      oob_q;
  logic [ADDR_WIDTH-1:0]     ram_addr_c;
  logic [DATA_WIDTH-1:0]     ram_rdata;

`ifdef MEM_ADDR_CHECK_EN
  logic fault_q;

  assign oob_c         = |bus.MemoryIn[MEM_IN_W-1:ADDR_WIDTH];
  assign bus.AddrFault = fault_q;
`else
  logic unused_upper_c;

  // Upper address bits are discarded: addresses wrap silently.
  assign unused_upper_c = ^bus.MemoryIn[MEM_IN_W-1:ADDR_WIDTH];
  assign oob_c          = 1'b0;
`endif

  // Next-state and per-cycle strobes.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    commit_c = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        if (bus.Write || bus.Read) begin
          accept_c = 1'b1;
          state_d  = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (cnt_q == '0) begin
          commit_c = 1'b1;
          state_d  = MEM_DONE;
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  // Reading the incoming address while idle makes the registered RAM output valid
  // from the cycle after acceptance, so even zero wait states can capture it.
  assign ram_addr_c = (state_q == MEM_IDLE) ? bus.MemoryIn[ADDR_WIDTH-1:0] : addr_q;
  assign we_c       = clear && commit_c && (op_q == OP_WRITE) && !oob_q;

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q     <= MEM_IDLE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      oob_q       <= 1'b0;
      read_data_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        op_q    <= bus.Write ? OP_WRITE : OP_READ;
        addr_q  <= bus.MemoryIn[ADDR_WIDTH-1:0];
        wdata_q <= bus.WriteData;
        cnt_q   <= WAIT_CNT_W'(WAIT_LOAD);
        oob_q   <= oob_c;
      end else if (state_q == MEM_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - WAIT_CNT_W'(1);
      end
      if (commit_c && op_q == OP_READ) begin
        read_data_q <= oob_q ? '0 : ram_rdata;
      end
      done_q <= (state_d == MEM_DONE);
      busy_q <= (state_d == MEM_WAIT) || (state_d == MEM_DONE);
    end
  end

`ifdef MEM_ADDR_CHECK_EN
  always_ff @(posedge clock) begin
    if (!clear) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= (state_d == MEM_DONE) && oob_q;
    end
  end
`endif

  assign bus.ReadData = read_data_q;
  assign bus.MemDone  = done_q;
  assign bus.Busy     = busy_q;

  ram_sp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clock(clock),
    .we   (we_c),
    .addr (ram_addr_c),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

endmodule
